alu_rr_sched: RTL and testbench

Round-robin scheduler that shares one WIDTH-bit shift/arithmetic unit (add, subtract, logical and arithmetic shifts, OR, XOR) between N_REQ requesters. It arbitrates requests, latches the winner's opcode and operands, and sequences the operation to completion. Multi-cycle shifts are performed one bit per cycle. It sits between the requesting blocks and the shared datapath register and returns a tagged result pulse.

---
 rtl/alu_rr_sched.sv | 202 ++++++++++++++++++++
 tb/tb_alu_rr_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one shift/arithmetic unit between N_REQ requesters.
// Define ALU_RR_SCHED_FAST_SHIFT_EN to use a single-cycle barrel shifter instead of iterative shifts.
module alu_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [3*N_REQ-1:0]       op,
    input  logic [WIDTH*N_REQ-1:0]   a,
    input  logic [WIDTH*N_REQ-1:0]   b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [WIDTH-1:0]         result
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]   S_MAX   = (WIDTH + 1)'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ASHL = 3'b100,
        OP_ASHR = 3'b101,
        OP_OR   = 3'b110,
        OP_XOR  = 3'b111
    } op_t;

    function automatic logic is_shift(input op_t o);
        return o inside {OP_SHL, OP_SHR, OP_ASHL, OP_ASHR};
    endfunction

    // Any shift amount of WIDTH or more behaves like a shift by exactly WIDTH.
    function automatic logic [CNT_W-1:0] sat_amt(input logic [WIDTH-1:0] v);
        if ({1'b0, v} >= S_MAX) return CNT_W'(WIDTH);
        return CNT_W'(v);
    endfunction

    function automatic logic [WIDTH-1:0] alu_eval(input op_t o, input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [CNT_W-1:0] s);
        case (o)
            OP_ADD:          return x + y;
            OP_SUB:          return x - y;
            OP_SHL, OP_ASHL: return x << s;
            OP_SHR:          return x >> s;
            OP_ASHR:         return $unsigned($signed(x) >>> s);
            OP_OR:           return x | y;
            OP_XOR:          return x ^ y;
            default:         return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_step(input op_t o, input logic [WIDTH-1:0] x);
        case (o)
            OP_SHL, OP_ASHL: return {x[WIDTH-2:0], 1'b0};
            OP_SHR:          return {1'b0, x[WIDTH-1:1]};
            OP_ASHR:         return {x[WIDTH-1], x[WIDTH-1:1]};
            default:         return x;
        endcase
    endfunction

    state_t            state_q, state_n;
    logic [N_REQ-1:0]  gnt_q, gnt_n;
    logic              done_q, done_n;
    logic [ID_W-1:0]   done_id_q, done_id_n;
    logic [WIDTH-1:0]  result_q, result_n;
    logic [ID_W-1:0]   ptr_q, ptr_n;
    op_t               op_q, op_n;
    logic [WIDTH-1:0]  work_q, work_n;
    logic [WIDTH-1:0]  b_q, b_n;
`ifndef ALU_RR_SCHED_FAST_SHIFT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_n;
`endif

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    op_t               sel_op;
    logic [WIDTH-1:0]  sel_a, sel_b;

    // Search upward from ptr+1 with wrap, so the last winner has lowest priority.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
        sel_op = op_t'(op[3*int'(win_idx) +: 3]);
        sel_a  = a[WIDTH*int'(win_idx) +: WIDTH];
        sel_b  = b[WIDTH*int'(win_idx) +: WIDTH];
    end

    always_comb begin
        state_n   = state_q;
        gnt_n     = '0;
        done_n    = 1'b0;
        done_id_n = done_id_q;
        result_n  = result_q;
        ptr_n     = ptr_q;
        op_n      = op_q;
        work_n    = work_q;
        b_n       = b_q;
`ifndef ALU_RR_SCHED_FAST_SHIFT_EN
        cnt_n     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_n   = N_REQ'(1) << win_idx;
                    ptr_n   = win_idx;
                    op_n    = sel_op;
                    work_n  = sel_a;
                    b_n     = sel_b;
`ifndef ALU_RR_SCHED_FAST_SHIFT_EN
                    cnt_n   = sat_amt(sel_b);
`endif
                    state_n = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_RR_SCHED_FAST_SHIFT_EN
                work_n  = alu_eval(op_q, work_q, b_q, sat_amt(b_q));
                state_n = DONE;
`else
                if (!is_shift(op_q)) begin
                    work_n  = alu_eval(op_q, work_q, b_q, '0);
                    state_n = DONE;
                end else if (cnt_q > CNT_ONE) begin
                    work_n = shift_step(op_q, work_q);
                    cnt_n  = cnt_q - CNT_ONE;
                end else begin
                    // cnt==0 finishes without touching the operand.
                    if (cnt_q == CNT_ONE) work_n = shift_step(op_q, work_q);
                    state_n = DONE;
                end
`endif
            end
            DONE: begin
                done_n    = 1'b1;
                result_n  = work_q;
                done_id_n = ptr_q;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            op_q      <= OP_ADD;
            work_q    <= '0;
            b_q       <= '0;
`ifndef ALU_RR_SCHED_FAST_SHIFT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            done_q    <= done_n;
            done_id_q <= done_id_n;
            result_q  <= result_n;
            ptr_q     <= ptr_n;
            op_q      <= op_n;
            work_q    <= work_n;
            b_q       <= b_n;
`ifndef ALU_RR_SCHED_FAST_SHIFT_EN
            cnt_q     <= cnt_n;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: stimulus pushes expected grants/results, monitors pop and compare.
// Latency expectations follow ALU_RR_SCHED_FAST_SHIFT_EN when defined.
module tb_alu_rr_sched;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ASHL = 3'b100;
    localparam logic [2:0] OP_ASHR = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] op;
    logic [35:0] a;
    logic [35:0] b;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [8:0]  result;

    alu_rr_sched #(.N_REQ(4), .WIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [8:0] res;
        int         lat;
    } exp_t;

    typedef struct {
        int         id;
        logic [2:0] o;
        logic [8:0] av;
        logic [8:0] bv;
        logic [8:0] res;
        int         lat_slow;
    } vec_t;

    // Hand-computed vectors; lat_slow is gnt-to-done distance with iterative shifts.
    vec_t vecs [13] = '{
        '{0, OP_ADD,  9'h1FF, 9'h002, 9'h001, 2},
        '{2, OP_ASHR, 9'h100, 9'h003, 9'h1E0, 4},
        '{1, OP_SHL,  9'h0FF, 9'h00C, 9'h000, 10},
        '{1, OP_SHR,  9'h0AB, 9'h000, 9'h0AB, 2},
        '{3, OP_SUB,  9'h050, 9'h0A1, 9'h1AF, 2},
        '{0, OP_OR,   9'h0F0, 9'h10F, 9'h1FF, 2},
        '{2, OP_XOR,  9'h155, 9'h0FF, 9'h1AA, 2},
        '{3, OP_ASHL, 9'h003, 9'h004, 9'h030, 5},
        '{0, OP_SHR,  9'h180, 9'h001, 9'h0C0, 2},
        '{1, OP_ASHR, 9'h0C0, 9'h1FF, 9'h000, 10},
        '{2, OP_ASHR, 9'h1C0, 9'h009, 9'h1FF, 10},
        '{3, OP_SHR,  9'h1FF, 9'h008, 9'h001, 9},
        '{0, OP_ADD,  9'h100, 9'h100, 9'h000, 2}
    };

    exp_t gq[$];
    exp_t dq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;
    int   last_done_cyc = -1;
    logic rr_mode = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
        end
    endtask

    function automatic int lat_of(input int slow);
`ifdef ALU_RR_SCHED_FAST_SHIFT_EN
        return (slow > 0) ? 2 : 2;
`else
        return slow;
`endif
    endfunction

    // Grant monitor
    always @(negedge clk) begin
        if (rst_n && gnt != 4'b0) begin
            if (gq.size() == 0) begin
                check("unexpected_gnt", {28'b0, gnt}, 32'h0);
            end else begin
                exp_t e;
                e = gq.pop_front();
                check($sformatf("gnt_onehot_r%0d", e.id), {28'b0, gnt}, 32'(1) << e.id);
                check("busy_with_gnt", {31'b0, busy}, 32'h1);
                if (rr_mode && last_done_cyc >= 0)
                    check("rr_gnt_after_done", cyc, last_done_cyc + 1);
                last_gnt_cyc = cyc;
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'h0);
            end else begin
                exp_t e;
                e = dq.pop_front();
                check($sformatf("done_id_r%0d", e.id), {30'b0, done_id}, e.id);
                check($sformatf("result_r%0d", e.id), {23'b0, result}, {23'b0, e.res});
                check($sformatf("latency_r%0d", e.id), cyc - last_gnt_cyc, e.lat);
            end
            last_done_cyc = cyc;
        end
    end

    task automatic drive(input int id, input logic [2:0] o, input logic [8:0] av, input logic [8:0] bv);
        op[3*id +: 3] = o;
        a[9*id +: 9]  = av;
        b[9*id +: 9]  = bv;
        req[id]       = 1'b1;
    endtask

    task automatic expect_op(input int id, input logic [8:0] res, input int lat);
        exp_t e;
        e.id = id; e.res = res; e.lat = lat;
        gq.push_back(e);
        dq.push_back(e);
    endtask

    task automatic wait_gnt(input int id);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gnt[id]) break;
        end
        check($sformatf("gnt_seen_r%0d", id), {31'b0, gnt[id]}, 32'h1);
        req[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && dq.size() == 0 && gq.size() == 0) break;
        end
        check("drained", {31'b0, busy | (dq.size() != 0)}, 32'h0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},     {28'b0, gnt},     32'h0);
        check({tag, "_busy"},    {31'b0, busy},    32'h0);
        check({tag, "_done"},    {31'b0, done},    32'h0);
        check({tag, "_done_id"}, {30'b0, done_id}, 32'h0);
        check({tag, "_result"},  {23'b0, result},  32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("post_release");

        foreach (vecs[i]) begin
            drive(vecs[i].id, vecs[i].o, vecs[i].av, vecs[i].bv);
            expect_op(vecs[i].id, vecs[i].res, lat_of(vecs[i].lat_slow));
            wait_gnt(vecs[i].id);
            wait_idle();
        end

        // Requester 0 raises and drops req while busy; only requester 3 should be granted.
        drive(1, OP_SHL, 9'h001, 9'h004);
        expect_op(1, 9'h010, lat_of(5));
        wait_gnt(1);
        drive(0, OP_ADD, 9'h001, 9'h001);
        @(negedge clk);
        req[0] = 1'b0;
        drive(3, OP_SUB, 9'h000, 9'h001);
        expect_op(3, 9'h1FF, 2);
        wait_gnt(3);
        wait_idle();

        // All requesters high from reset: rotation 0,1,2,3,0 back-to-back.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, OP_ADD, 9'(i + 1), 9'h010);
        rr_mode = 1'b1;
        last_done_cyc = -1;
        expect_op(0, 9'h011, 2);
        expect_op(1, 9'h012, 2);
        expect_op(2, 9'h013, 2);
        expect_op(3, 9'h014, 2);
        expect_op(0, 9'h011, 2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (gq.size() == 0) break;
        end
        req = '0;
        check("rr_all_granted", gq.size(), 0);
        wait_idle();
        rr_mode = 1'b0;

        // Reset during the 3rd EXEC cycle of a 5-bit shift aborts with no done.
        begin
            exp_t e;
            e.id = 2; e.res = 9'h00F; e.lat = 0;
            gq.push_back(e);
        end
        drive(2, OP_SHR, 9'h1F0, 9'h005);
        wait_gnt(2);
`ifndef ALU_RR_SCHED_FAST_SHIFT_EN
        repeat (2) @(negedge clk);
`endif
        #1 rst_n = 1'b0;
        #2 check_reset("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_reset("after_abort");

        drive(0, OP_ADD, 9'h00A, 9'h005);
        drive(3, OP_XOR, 9'h1FF, 9'h0F0);
        expect_op(0, 9'h00F, 2);
        expect_op(3, 9'h10F, 2);
        wait_gnt(0);
        wait_gnt(3);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
